// File: rtl/seq_add_sub_pkg.sv
// seq_add_sub_pkg: shared FSM state encoding and sizing helpers for the multi-cycle adder/subtractor
package seq_add_sub_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/add_chunk.sv
// add_chunk: combinational CHUNK-bit ripple adder exposing the carry into its top bit
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);
  assign {c_out, s} = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(c_in);
  // the sum bit is a^b^carry, so the carry into the MSB falls out of the MSB's own sum
  assign c_msb_in = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
endmodule

// File: rtl/seq_add_sub.sv
// seq_add_sub: WIDTH-bit add/subtract computed CHUNK bits per clock behind valid/ready handshakes
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);
  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, s_nx;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] sum;
  logic             carry, co, cm, last;
  int               base;
  assign base = CHUNK * int'(cnt);
  assign last = cnt == CW'(N - 1);
  add_chunk #(.CHUNK(CHUNK)) u_add (
    .a        (a_r[base +: CHUNK]),
    .b        (b_r[base +: CHUNK]),
    .c_in     (carry),
    .s        (sum),
    .c_out    (co),
    .c_msb_in (cm)
  );
  // full result with the current chunk merged in, so zero sees the final slice on the last edge
  always_comb begin
    s_nx = s;
    s_nx[base +: CHUNK] = sum;
  end
  // handshake FSM: latch operands, ripple one chunk per cycle, hold result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_r      <= a;
          b_r      <= sub ? ~b : b;
          carry    <= sub ? ~c_in : c_in;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          s     <= s_nx;
          carry <= co;
          cnt   <= last ? cnt : cnt + 1'b1;
          if (last) begin
            c_out     <= co;
            ovf       <= cm ^ co;
            zero      <= s_nx == '0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_add_sub.sv
// tb_seq_add_sub: directed vector bench for seq_add_sub at CHUNK=8 and CHUNK=32
module tb_seq_add_sub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        sub = 1'b0, c_in = 1'b0;
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic        in_ready1, out_valid1, c_out1, ovf1, zero1;
  logic        in_ready2, out_valid2, c_out2, ovf2, zero2;
  logic [31:0] s1, s2;
  logic        sel = 1'b0;
  int          n_vec = 0, n_err = 0, n_chk = 0;

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a), .b(b),
    .sub(sub), .c_in(c_in), .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .c_out(c_out1), .ovf(ovf1), .zero(zero1)
  );
  seq_add_sub #(.WIDTH(32), .CHUNK(32)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a), .b(b),
    .sub(sub), .c_in(c_in), .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .c_out(c_out2), .ovf(ovf2), .zero(zero2)
  );

  logic        ov, ir, co, of, zr;
  logic [31:0] sv;
  assign ov = sel ? out_valid2 : out_valid1;
  assign ir = sel ? in_ready2  : in_ready1;
  assign co = sel ? c_out2     : c_out1;
  assign of = sel ? ovf2       : ovf1;
  assign zr = sel ? zero2      : zero1;
  assign sv = sel ? s2         : s1;

  typedef struct {
    logic [31:0] a, b;
    logic        sub, c_in;
    logic [31:0] s;
    logic        c_out, ovf, zero;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (dut%0d): got %h want %h", name, sel ? 2 : 1, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer operands, check the accept and the latency to out_valid, then scramble the ports
  task automatic start_op(input logic [31:0] xa, input logic [31:0] xb, input logic xs, input logic xc);
    int k;
    a = xa; b = xb; sub = xs; c_in = xc;
    chk("in_ready_before_accept", 32'(ir), 32'd1);
    if (sel) in_valid2 = 1'b1; else in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    a = $urandom; b = $urandom; sub = ~xs; c_in = ~xc;
    chk("in_ready_after_accept", 32'(ir), 32'd0);
    k = 0;
    while (!ov && k < 20) begin
      tick();
      k++;
    end
    chk("latency", 32'(k), sel ? 32'd1 : 32'd4);
  endtask

  task automatic chk_res(input string tag, input vec_t v);
    chk({tag, " s"},     sv,        v.s);
    chk({tag, " c_out"}, 32'(co),   32'(v.c_out));
    chk({tag, " ovf"},   32'(of),   32'(v.ovf));
    chk({tag, " zero"},  32'(zr),   32'(v.zero));
  endtask

  task automatic release_op();
    if (sel) out_ready2 = 1'b1; else out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0; out_ready2 = 1'b0;
    chk("release out_valid", 32'(ov), 32'd0);
    chk("release in_ready",  32'(ir), 32'd1);
  endtask

  task automatic run_vec(input int i);
    start_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].c_in);
    chk_res($sformatf("v%0d", i), tbl[i]);
    release_op();
    n_vec++;
  endtask

  initial begin
    //        a             b             sub   c_in  s             c_out ovf   zero
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h0000ABCD, 32'h0000ABCD, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b1, 32'h00000101, 1'b0, 1'b0, 1'b0};

    tick(); tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #0;
      chk("reset in_ready",  32'(ir), 32'd1);
      chk("reset out_valid", 32'(ov), 32'd0);
      chk("reset s",         sv,      32'd0);
      chk("reset c_out",     32'(co), 32'd0);
      chk("reset ovf",       32'(of), 32'd0);
      chk("reset zero",      32'(zr), 32'd0);
    end
    tick();

    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int i = 0; i < 10; i++) run_vec(i);
    end
    sel = 1'b0;

    // backpressure: result held for 10 cycles while new operands are offered
    start_op(tbl[1].a, tbl[1].b, tbl[1].sub, tbl[1].c_in);
    in_valid1 = 1'b1;
    a = 32'h11111111; b = 32'h22222222; sub = 1'b0; c_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 9) in_valid1 = 1'b0;
      chk_res($sformatf("hold%0d", k), tbl[1]);
      chk($sformatf("hold%0d out_valid", k), 32'(ov), 32'd1);
      chk($sformatf("hold%0d in_ready", k),  32'(ir), 32'd0);
    end
    n_vec++;
    release_op();
    run_vec(5);

    // reset lands on the second RUN edge; the op must vanish without a result
    start_op_abort();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post_rst%0d out_valid", k), 32'(ov), 32'd0);
    end
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic start_op_abort();
    a = tbl[0].a; b = tbl[0].b; sub = tbl[0].sub; c_in = tbl[0].c_in;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort in_ready",  32'(ir), 32'd1);
    chk("abort out_valid", 32'(ov), 32'd0);
    chk("abort s",         sv,      32'd0);
    chk("abort zero",      32'(zr), 32'd0);
    n_vec++;
  endtask
endmodule
